// File: rtl/ksa_arb_pkg.sv
// rtl/ksa_arb_pkg.sv - shared state type, data width and index-width helper for ksa_arbiter
package ksa_arb_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // Never returns 0 so a requester index always has at least one bit.
  function automatic int idw_f(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ksa16.sv
// rtl/ksa16.sv - 16-bit Kogge-Stone adder, carry-in fixed at 0
module ksa16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum,
  output logic        cout
);

  logic [15:0] g [0:4];
  logic [15:0] p [0:3];

  assign g[0] = a & b;
  assign p[0] = a ^ b;

  // Each level doubles the span; bits below the span keep their previous group terms.
  for (genvar l = 1; l <= 4; l++) begin : g_lvl
    localparam int D = 1 << (l - 1);
    assign g[l] = g[l-1] | (p[l-1] & {g[l-1][15-D:0], {D{1'b0}}});
    if (l < 4) begin : g_prop
      assign p[l] = p[l-1] & {p[l-1][15-D:0], {D{1'b1}}};
    end
  end

  assign sum  = p[0] ^ {g[4][14:0], 1'b0};
  assign cout = g[4][15];

endmodule

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker, searching upward from rr_ptr
module rr_pick import ksa_arb_pkg::*; #(
  parameter  int NUM_REQ = 4,
  localparam int IDW     = idw_f(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDW-1:0]     rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     winner,
  output logic               any_valid
);

  int idx;

  // Walk offsets from farthest to nearest so the nearest valid requester wins last.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    grant     = '0;
    idx       = 0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      idx = (int'(rr_ptr) + off) % NUM_REQ;
      if (req_valid[idx]) begin
        winner    = IDW'(idx);
        any_valid = 1'b1;
      end
    end
    if (any_valid) grant[winner] = 1'b1;
  end

endmodule

// File: rtl/ksa_arbiter.sv
// rtl/ksa_arbiter.sv - round-robin sequencer sharing one KSA16 between NUM_REQ requesters
// Define KSA_ARB_SAT_EN to saturate the sum to 16'hFFFF whenever the adder carries out.
module ksa_arbiter import ksa_arb_pkg::*; #(
  parameter  int NUM_REQ = 4,
  parameter  int CNT_W   = 16,
  localparam int IDW     = idw_f(NUM_REQ)
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [DATA_W*NUM_REQ-1:0] req_a,
  input  logic [DATA_W*NUM_REQ-1:0] req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_sum,
  output logic                      rsp_cout,
  output logic [IDW-1:0]            rsp_id,
  output logic                      busy,
  output logic [CNT_W-1:0]          op_count
);

  state_e              state_q, state_d;
  logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
  logic [DATA_W-1:0]   op_a_q, op_a_d;
  logic [DATA_W-1:0]   op_b_q, op_b_d;
  logic [IDW-1:0]      id_q, id_d;
  logic [DATA_W-1:0]   sum_q, sum_d;
  logic                cout_q, cout_d;
  logic [CNT_W-1:0]    op_count_q, op_count_d;

  logic [NUM_REQ-1:0]  grant;
  logic [IDW-1:0]      winner;
  logic                any_valid;
  logic [DATA_W-1:0]   add_sum;
  logic                add_cout;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_q),
    .grant     (grant),
    .winner    (winner),
    .any_valid (any_valid)
  );

  ksa16 u_add (
    .a    (op_a_q),
    .b    (op_b_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    id_d       = id_q;
    sum_d      = sum_q;
    cout_d     = cout_q;
    op_count_d = op_count_q;
    req_ready  = '0;
    rsp_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = grant;
        if (any_valid) begin
          op_a_d   = req_a[int'(winner)*DATA_W +: DATA_W];
          op_b_d   = req_b[int'(winner)*DATA_W +: DATA_W];
          id_d     = winner;
          rr_ptr_d = (int'(winner) == NUM_REQ - 1) ? '0 : winner + 1'b1;
          state_d  = EXEC;
        end
      end
      EXEC: begin
`ifdef KSA_ARB_SAT_EN
        sum_d = add_cout ? {DATA_W{1'b1}} : add_sum;
`else
        sum_d = add_sum;
`endif
        cout_d  = add_cout;
        state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          op_count_d = op_count_q + 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      id_q       <= '0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      id_q       <= id_d;
      sum_q      <= sum_d;
      cout_q     <= cout_d;
      op_count_q <= op_count_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign rsp_sum  = sum_q;
  assign rsp_cout = cout_q;
  assign rsp_id   = id_q;
  assign op_count = op_count_q;

endmodule

// File: tb/tb_ksa_arbiter.sv
// tb/tb_ksa_arbiter.sv - cycle model plus result scoreboard for ksa_arbiter
module tb_ksa_arbiter;

  localparam int N     = 4;
  localparam int IDW   = 2;
  localparam int CNT_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [16*N-1:0]   req_a;
  logic [16*N-1:0]   req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [15:0]       rsp_sum;
  logic              rsp_cout;
  logic [IDW-1:0]    rsp_id;
  logic              busy;
  logic [CNT_W-1:0]  op_count;

  typedef struct {
    int          id;
    logic [15:0] sum;
    logic        cout;
  } exp_t;

  exp_t sb[$];
  int   g_id[$];
  int   g_cyc[$];

  int               n_checks = 0;
  int               n_fail   = 0;
  int               cyc      = 0;
  int               n_done   = 0;
  bit               chk_en   = 1'b0;
  int               m_state  = 0;
  int               m_ptr    = 0;
  logic [CNT_W-1:0] m_count  = '0;

  ksa_arbiter #(.NUM_REQ(N), .CNT_W(CNT_W)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_id    (rsp_id),
    .busy      (busy),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  // Reference model: predicts handshakes, state outputs and results one cycle at a time.
  initial forever begin
    int           win;
    logic [N-1:0] exp_rdy;
    exp_t         e;
    @(negedge clk);
    win     = -1;
    exp_rdy = '0;
    if (m_state == 0)
      for (int k = 0; k < N; k++)
        if (win < 0 && req_valid[(m_ptr + k) % N]) win = (m_ptr + k) % N;
    if (win >= 0) exp_rdy[win] = 1'b1;
    if (chk_en) begin
      check("req_ready", req_ready, exp_rdy);
      check("busy", busy, m_state != 0);
      check("rsp_valid", rsp_valid, m_state == 2);
      check("op_count", op_count, m_count);
      if (m_state == 2 && sb.size() > 0) begin
        check("rsp_sum", rsp_sum, sb[0].sum);
        check("rsp_cout", rsp_cout, sb[0].cout);
        check("rsp_id", rsp_id, sb[0].id);
      end
    end
    if (rst) begin
      m_state = 0;
      m_ptr   = 0;
      m_count = '0;
      sb.delete();
    end else begin
      case (m_state)
        0: if (win >= 0) begin
          e.id = win;
          {e.cout, e.sum} = {1'b0, req_a[win*16 +: 16]} + {1'b0, req_b[win*16 +: 16]};
`ifdef KSA_ARB_SAT_EN
          if (e.cout) e.sum = 16'hFFFF;
`endif
          sb.push_back(e);
          g_id.push_back(win);
          g_cyc.push_back(cyc);
          m_ptr   = (win + 1) % N;
          m_state = 1;
        end
        1: m_state = 2;
        default: if (rsp_ready) begin
          void'(sb.pop_front());
          m_count = m_count + 1'b1;
          n_done++;
          m_state = 0;
        end
      endcase
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) tick();
    rst = 1'b0;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_sum", rsp_sum, 0);
    check("rst_rsp_cout", rsp_cout, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_op_count", op_count, 0);
  endtask

  task automatic send(input int i, input logic [15:0] a, input logic [15:0] b);
    logic got;
    got = 1'b0;
    req_a[i*16 +: 16] = a;
    req_b[i*16 +: 16] = b;
    req_valid[i] = 1'b1;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      if (req_ready[i]) got = 1'b1;
    end
    check("send_accept", got, 1);
    tick();
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      tick();
      if (!busy && sb.size() == 0) done = 1'b1;
    end
    check("idle_reached", done, 1);
  endtask

  task automatic wait_grant();
    logic done;
    done = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      tick();
      if (g_id.size() > 0) done = 1'b1;
    end
    check("grant_seen", done, 1);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    tick();
    chk_en = 1'b1;
    do_reset(2);

    // Basic sum, then carry-out case.
    send(0, 16'h1234, 16'h4321);
    wait_idle();
    check("t1_op_count", op_count, 1);
    send(1, 16'hFFFF, 16'h0001);
    wait_idle();
`ifdef KSA_ARB_SAT_EN
    check("t2_sum_sat", rsp_sum, 16'hFFFF);
`else
    check("t2_sum_wrap", rsp_sum, 16'h0000);
`endif
    check("t2_cout", rsp_cout, 1);
    for (int k = 0; k < 8; k++)
      send($urandom_range(0, N - 1), 16'($urandom), 16'($urandom));
    wait_idle();

    // All requesters valid continuously.
    do_reset(1);
    g_id.delete();
    g_cyc.delete();
    for (int i = 0; i < N; i++) begin
      req_a[i*16 +: 16] = 16'($urandom);
      req_b[i*16 +: 16] = 16'($urandom);
    end
    req_valid = '1;
    repeat (14) tick();
    req_valid = '0;
    wait_idle();
    check("rr_grant_count_ge5", g_id.size() >= 5, 1);
    for (int k = 0; k < 5 && k < g_id.size(); k++) begin
      check("rr_order", g_id[k], k % N);
      if (k > 0) check("rr_gap", g_cyc[k] - g_cyc[k-1], 3);
    end

    // Consumer stall in RESP, then release.
    do_reset(1);
    rsp_ready = 1'b0;
    send(2, 16'hA5A5, 16'h5A5A);
    req_a[1*16 +: 16] = 16'h0101;
    req_b[1*16 +: 16] = 16'h0202;
    req_a[3*16 +: 16] = 16'h8000;
    req_b[3*16 +: 16] = 16'h8001;
    req_valid[1] = 1'b1;
    req_valid[3] = 1'b1;
    repeat (11) tick();
    check("stall_busy", busy, 1);
    check("stall_rsp_valid", rsp_valid, 1);
    check("stall_req_ready", req_ready, 0);
    g_id.delete();
    rsp_ready = 1'b1;
    wait_grant();
    req_valid = '0;
    check("stall_next_grant", (g_id.size() > 0) ? g_id[0] : -1, 3);
    wait_idle();

    // Reset while the pair is in EXEC: it must vanish and rr_ptr return to 0.
    req_a[1*16 +: 16] = 16'h1111;
    req_b[1*16 +: 16] = 16'h2222;
    req_valid[1] = 1'b1;
    begin
      logic got;
      got = 1'b0;
      for (int c = 0; c < 50 && !got; c++) begin
        @(negedge clk);
        if (req_ready[1]) got = 1'b1;
      end
      check("exec_accept", got, 1);
    end
    tick();
    req_valid = '0;
    check("exec_busy_before_rst", busy, 1);
    do_reset(1);
    repeat (8) tick();
    g_id.delete();
    req_valid[0] = 1'b1;
    req_valid[3] = 1'b1;
    wait_grant();
    req_valid = '0;
    check("post_rst_grant", (g_id.size() > 0) ? g_id[0] : -1, 0);
    wait_idle();

    // Counter wrap: 2^CNT_W completions from reset bring op_count back to 0.
    do_reset(1);
    begin
      int  base;
      logic done;
      base = n_done;
      done = 1'b0;
      req_a[15:0] = 16'h7FFF;
      req_b[15:0] = 16'h0003;
      req_valid[0] = 1'b1;
      for (int c = 0; c < 2000 && !done; c++) begin
        tick();
        if (n_done - base >= (1 << CNT_W)) done = 1'b1;
      end
      check("wrap_reached", done, 1);
      check("wrap_op_count", op_count, 0);
      req_valid = '0;
    end
    wait_idle();

    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
